// File: rtl/dm_pkg.sv
// Shared definitions for the dm_stall data-memory block: state encoding,
// wait counter width and byte-lane width.
package dm_pkg;

    localparam int CNT_W  = 4;
    localparam int BYTE_W = 8;

    localparam logic [1:0] DM_IDLE = 2'd0;
    localparam logic [1:0] DM_WAIT = 2'd1;
    localparam logic [1:0] DM_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = DM_IDLE,
        ST_WAIT = DM_WAIT,
        ST_RESP = DM_RESP
    } dm_state_e;

endpackage

// File: rtl/dm_stall_merge.sv
// dm_merge: byte-lane merge of store data into the old memory word.
// Shared by the write path and the optional store log so both see the same word.
module dm_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  bee,
    output logic [31:0] new_word
);

    // lanes with bee set take the store data, the rest keep the old bytes
    always_comb begin
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (bee[i]) begin
                new_word[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/dm_stall.sv
// dm_stall: word-organised data memory with a programmable number of wait
// cycles per access and busy/done handshake for MEM-stage stalling.
// Optional macro DM_DISPLAY_EN: logs every store commit with bee != 0
// (time, pc, byte address, merged word).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding, a request is accepted
// WAIT  | access latched, counting down wait cycles, busy=1
// RESP  | access committed, done=1 for one cycle, a new request may be accepted
module dm_stall
    import dm_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  bee,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done
);

    localparam int DEPTH = 1 << ADDR_W;

    dm_state_e          state;
    dm_state_e          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  idx_q;
    logic               we_q;
    logic [3:0]         bee_q;
    logic [31:0]        wdata_q;
    logic               accept;
    logic               commit;

    // The array itself has no reset; a per-word valid bit cleared by reset
    // makes every word read as zero until it is next written.
    logic [31:0]        mem [DEPTH];
    logic [DEPTH-1:0]   vld;
    logic [31:0]        old_word;
    logic [31:0]        merged;

    assign old_word = vld[idx_q] ? mem[idx_q] : 32'h0;

    dm_merge u_merge (
        .old_word (old_word),
        .wdata    (wdata_q),
        .bee      (bee_q),
        .new_word (merged)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, handshake outputs and accept/commit strobes
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                done = 1'b1;
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // request latch, wait counter and load data register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            bee_q   <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            if (accept) begin
                idx_q   <= addr[ADDR_W+1:2];
                we_q    <= we;
                bee_q   <= bee;
                wdata_q <= wdata;
                cnt     <= CNT_W'(WAIT_CYC);
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit && !we_q) begin
                rdata <= old_word;
            end
        end
    end

    // word valid bits: cleared by reset, set by any store commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else if (commit && we_q) begin
            vld[idx_q] <= 1'b1;
        end
    end

    // storage array write on store commit
    always_ff @(posedge clk) begin
        if (commit && we_q) begin
            mem[idx_q] <= merged;
        end
    end

`ifdef DM_DISPLAY_EN
    logic unused_ok;
    assign unused_ok = ^{addr[31:ADDR_W+2], addr[1:0]};

    // pc of the stored access, held alongside the other request fields
    logic [31:0] pc_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (accept) begin
            pc_q <= pc;
        end
    end

    // log each store that actually changes lanes
    always_ff @(posedge clk) begin
        if (!reset && commit && we_q && bee_q != 4'b0000) begin
            $display("[dm_stall] t=%0t pc=%08h addr=%08h data=%08h",
                     $time, pc_q, 32'({idx_q, 2'b00}), merged);
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{addr[31:ADDR_W+2], addr[1:0], pc};
`endif

endmodule

// File: tb/tb_dm_stall.sv
// Self-checking bench for dm_stall: directed table, back-to-back and reset
// sequences, WAIT_CYC=0 wrap instance, and randomized accesses against a
// word-array reference model.
module tb_dm_stall;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  bee = '0;
    logic [31:0] wdata = '0;
    logic [31:0] pc = '0;
    logic [31:0] rdata, rdata0;
    logic        busy, busy0, done, done0;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [0:4095];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    dm_stall #(.ADDR_W(12), .WAIT_CYC(WC)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .bee(bee),
        .wdata(wdata), .pc(pc), .rdata(rdata), .busy(busy), .done(done)
    );

    dm_stall #(.ADDR_W(12), .WAIT_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .bee(bee),
        .wdata(wdata), .pc(pc), .rdata(rdata0), .busy(busy0), .done(done0)
    );

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    // reference for the main instance: word index is byte address / 4 mod 4096
    task automatic model_apply(input bit w, input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d);
        int idx;
        idx = int'((a >> 2) % 4096);
        if (w) model[idx] = merge_ref(model[idx], d, b);
        else   last_rd = model[idx];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4096; i++) model[i] = '0;
        last_rd = '0;
    endtask

    // one access from a negedge; returns at the negedge after the done cycle
    task automatic access(input bit sel, input bit w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          input int exp_lat, output logic [31:0] rd);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        we = w; addr = a; bee = b; wdata = d; pc = $urandom;
        if (sel) req0 = 1'b1;
        else     req  = 1'b1;
        @(posedge clk);
        #1;
        req  = 1'b0;
        req0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sel ? done0 : done) begin
                seen = 1;
                break;
            end
            if (sel ? busy0 : busy) lat++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", lat, exp_lat);
        rd = sel ? rdata0 : rdata;
        @(negedge clk);
        check("done_one_cycle", 32'(sel ? done0 : done), 32'd0);
        check("idle_not_busy", 32'(sel ? busy0 : busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] prev;
        int n, t_a, t_b;

        tbl[0]  = '{0, 32'h0000_0014, 4'hF, 32'h0,         32'h0000_0000};
        tbl[1]  = '{1, 32'h0000_0020, 4'hF, 32'hAABB_CCDD, 32'h0};
        tbl[2]  = '{1, 32'h0000_0020, 4'h2, 32'h0000_1100, 32'h0};
        tbl[3]  = '{0, 32'h0000_0020, 4'h0, 32'h0,         32'hAABB_11DD};
        tbl[4]  = '{1, 32'h0000_0040, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[5]  = '{1, 32'h0000_0040, 4'hC, 32'h1234_0000, 32'h0};
        tbl[6]  = '{0, 32'h0000_0040, 4'h5, 32'h0,         32'h1234_FFFF};
        tbl[7]  = '{1, 32'h0000_0040, 4'h0, 32'h5555_5555, 32'h0};
        tbl[8]  = '{0, 32'h0000_0040, 4'hF, 32'h0,         32'h1234_FFFF};
        tbl[9]  = '{0, 32'h0000_4023, 4'hF, 32'h0,         32'hAABB_11DD};
        tbl[10] = '{1, 32'hFFFF_C020, 4'h1, 32'h0000_0077, 32'h0};

        model_clear();
        #2;
        check("reset_rdata", rdata, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // directed table; stores must leave rdata at the last loaded value
        prev = '0;
        for (int i = 0; i < 11; i++) begin
            model_apply(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d);
            access(0, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, WC + 1, rd);
            if (tbl[i].w) begin
                check("table_store_rdata", rd, prev);
            end else begin
                check("table_load", rd, tbl[i].exp);
                prev = tbl[i].exp;
            end
        end
        access(0, 0, 32'h0000_0020, 4'hF, 32'h0, WC + 1, rd);
        model_apply(0, 32'h0000_0020, 4'hF, 32'h0);
        check("wrap_store_lane0", rd, 32'hAABB_1177);

        // back-to-back: req held through first done, stray req during WAIT
        n = 0; t_a = -1; t_b = -1;
        we = 1'b1; addr = 32'h60; bee = 4'hF; wdata = 32'h1122_3344; req = 1'b1;
        for (int k = 0; k < 40 && t_a < 0; k++) begin
            @(negedge clk);
            n++;
            if (done) t_a = n;
        end
        we = 1'b0; addr = 32'h60; bee = 4'hF; wdata = 32'h0;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        n++;
        check("b2b_second_busy", 32'(busy), 32'd1);
        req = 1'b1; we = 1'b1; addr = 32'h64; wdata = 32'hCAFE_BABE; bee = 4'hF;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int k = 0; k < 40 && t_b < 0; k++) begin
            @(negedge clk);
            n++;
            if (done) t_b = n;
        end
        check("b2b_first_done", 32'(t_a > 0), 32'd1);
        check("b2b_spacing", t_b - t_a, WC + 2);
        check("b2b_rdata", rdata, 32'h1122_3344);
        @(negedge clk);
        check("b2b_no_extra_done", 32'(done), 32'd0);
        model_apply(1, 32'h60, 4'hF, 32'h1122_3344);
        model_apply(0, 32'h60, 4'hF, 32'h0);
        access(0, 0, 32'h64, 4'hF, 32'h0, WC + 1, rd);
        model_apply(0, 32'h64, 4'hF, 32'h0);
        check("wait_req_ignored", rd, last_rd);

        // reset in WAIT of a store
        access(0, 0, 32'h60, 4'hF, 32'h0, WC + 1, rd);
        check("pre_reset_load", rd, 32'h1122_3344);
        we = 1'b1; addr = 32'h8; bee = 4'hF; wdata = 32'hDEAD_BEEF; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        access(0, 0, 32'h8, 4'hF, 32'h0, WC + 1, rd);
        check("rst_dropped_store", rd, 32'h0);
        access(0, 0, 32'h20, 4'hF, 32'h0, WC + 1, rd);
        check("rst_mem_cleared", rd, 32'h0);

        // zero-wait instance with address wrap
        access(1, 1, 32'h0000_4004, 4'hF, 32'h0BAD_F00D, 1, rd);
        access(1, 0, 32'h0000_0004, 4'hF, 32'h0, 1, rd);
        check("wc0_wrap_load", rd, 32'h0BAD_F00D);

        // randomized accesses against the reference model
        for (int i = 0; i < 40; i++) begin
            bit          w;
            logic [31:0] a, d;
            logic [3:0]  b;
            w = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 7)) << 2);
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            model_apply(w, a, b, d);
            access(0, w, a, b, d, WC + 1, rd);
            check("rand_rdata", rd, last_rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_stall.md
Name: dm_stall

Overview:
- Data-memory block with wait states, sitting downstream of the byte-enable generator in the MEM stage.
- Consumes the 4-bit byte-enable mask together with address and store data.
- Performs byte-masked writes or full-word reads after a programmable number of wait cycles.
- Reports busy/done so the pipeline controller can stall the MEM stage while an access is outstanding.

Parameters:
- ADDR_W, 12, word-address bits; memory depth is 2^ADDR_W 32-bit words.
- WAIT_CYC, 2, wait cycles inserted before each access commits (0..15 legal).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request; sampled only when the block can accept.
- we  input  1  1 = store, 0 = load; latched on acceptance.
- addr  input  32  byte address; bits [ADDR_W+1:2] select the word, all other bits are ignored.
- bee  input  4  byte-enable mask from the upstream byte-enable generator; bit i gates byte lane i (bits [8i+7:8i]).
- wdata  input  32  store data, already lane-aligned.
- pc  input  32  PC of the requesting instruction; used only by the optional log.
- rdata  output  32  registered load data.
- busy  output  1  access pending; pipeline must stall.
- done  output  1  one-cycle pulse: access committed, rdata valid for loads.

Behaviour:
- States: IDLE, WAIT, RESP. A 4-bit down-counter cnt is used in WAIT.
- Reset (async, immediate):
  - state=IDLE, cnt=0, rdata=0, busy=0, done=0.
  - Every memory word is cleared to 0.
  - An in-flight access is dropped; no partial write occurs.
- Acceptance:
  - A request is accepted at a rising edge when req=1 and state is IDLE or RESP.
  - On acceptance, addr word index, we, bee and wdata are latched; cnt<=WAIT_CYC; state<=WAIT.
- req while in WAIT is ignored. No queueing; upstream holds its request until done.
- WAIT state:
  - busy=1.
  - Each edge with cnt!=0 decrements cnt.
  - At the edge where cnt==0 the access commits and state<=RESP.
- Commit:
  - Store: mem[idx] lane i <= wdata lane i for each bee[i]=1; other lanes keep their old value.
  - bee=0000 on a store completes normally and modifies nothing.
  - Load: rdata <= mem[idx], full word; bee is ignored. Sign/zero extension is the writeback stage's job.
  - rdata holds its value until the next load commit or reset. A store commit does not change rdata.
- RESP state: busy=0, done=1 for exactly one cycle. Next state is WAIT if a new request is accepted, else IDLE.
- Latency: with acceptance at edge t, commit happens at edge t+WAIT_CYC+1 and done is high in the following cycle. With WAIT_CYC=0, done is high in the cycle after edge t+1.
- Back-to-back: a request accepted in RESP overlaps the done pulse of the previous access, giving one access every WAIT_CYC+2 cycles.
- Address wrap: upper address bits are discarded, so addr 0x0000_4000 aliases word 0 when ADDR_W=12.
- Simultaneous reset and commit: reset wins; the memory is cleared.

Optional Feature:
- Macro DM_DISPLAY_EN.
- Defined: on every store commit that has at least one bee bit set, the block prints via $display: time, pc, the byte address (idx<<2), and the merged 32-bit word written.
- Undefined: no display logic is compiled; pc is unused. Timing and functional behaviour are identical in both builds.

Decomposition:
- Shared package dm_pkg:
  - State encoding constants DM_IDLE=2'd0, DM_WAIT=2'd1, DM_RESP=2'd2.
  - CNT_W=4.
  - Lane-width constant BYTE_W=8.
- One sub-module, dm_merge: combinational merge of old word, wdata and bee into the new word. It is reused by the display path so the logged value matches the stored value.

Test Plan:
- Reset, then load of word 5 (addr 0x14) with WAIT_CYC=2 -> busy high for 3 cycles, then done one cycle with rdata=0x0000_0000.
- Store 0xAABBCCDD to 0x20 with bee=1111, then store 0x0000_1100 with bee=0010 -> load 0x20 returns 0xAABB11DD.
- Store with bee=1100 and data 0x1234_0000 to 0x40, pre-filled with 0xFFFF_FFFF -> load returns 0x1234_FFFF. Store with bee=0000 -> word unchanged, done still pulses.
- Back-to-back: second req held high through the done cycle of the first -> second access accepted in RESP; accesses complete 4 cycles apart with WAIT_CYC=2; req asserted during WAIT is ignored.
- Reset asserted in WAIT of a store to 0x8 with data 0xDEADBEEF -> outputs go to 0 immediately; a later load of 0x8 returns 0.
- WAIT_CYC=0 build, with a store to addr 0x0000_4004 and ADDR_W=12 -> done in the cycle after acceptance+1; a load of 0x4 returns the stored word (wrap). With DM_DISPLAY_EN defined, exactly one log line is printed per store with bee!=0.
